uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_idle_timer.sv | 47 ++++
 rtl/uart_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: status bit layout,
// entry format and parameter defaults.
package uart_pkg;

  // Bit positions inside status_out
  localparam int OVR_BIT    = 7;
  localparam int H_PERR_BIT = 6;
  localparam int H_FERR_BIT = 5;
  localparam int TMO_BIT    = 4;
  localparam int CNT_MSB    = 3;
  localparam int CNT_LSB    = 0;

  // Parameter defaults
  localparam int          DEPTH_DEF   = 8;
  localparam logic [15:0] TIMEOUT_DEF = 16'd4000;

  // One stored byte with its {PERR, FERR} flags
  typedef struct packed {
    logic [1:0] err;
    logic [7:0] data;
  } rx_entry_t;

  // Assemble the status byte from its fields using the shared bit positions
  function automatic logic [7:0] pack_status(
    input logic       ovr,
    input logic [1:0] head_err,
    input logic       tmo,
    input logic [3:0] cnt
  );
    logic [7:0] v;
    v = 8'h00;
    v[OVR_BIT]          = ovr;
    v[H_PERR_BIT]       = head_err[1];
    v[H_FERR_BIT]       = head_err[0];
    v[TMO_BIT]          = tmo;
    v[CNT_MSB:CNT_LSB]  = cnt;
    return v;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer: counts clocks without FIFO activity, saturates at TIMEOUT.
// o_done is high whenever the count is at (or is about to reach) TIMEOUT,
// so the owner can set its flag on the same edge the count gets there.
module uart_idle_timer #(
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_done
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  // Next count: clear wins, otherwise increment until saturated
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = 16'd0;
    end else if (r_cnt >= TIMEOUT) begin
      w_cnt_nxt = TIMEOUT;
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Done flag reflects the value the counter holds after this edge
  always_comb begin
    o_done = 1'b0;
    if (w_cnt_nxt == TIMEOUT) begin
      o_done = 1'b1;
    end else begin
      o_done = 1'b0;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word-fall-through head, sticky overrun,
// idle timeout flag and a registered level interrupt request.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          DEPTH   = DEPTH_DEF,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [1:0] rx_err,
  input  logic       rd_data,
  input  logic       rd_status,
  input  logic [3:0] thresh,
  output logic [7:0] data_out,
  output logic [7:0] status_out,
  output logic       int_req,
  output logic       empty,
  output logic       full
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  rx_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovr;
  logic            r_tmo;
  logic            r_int;

  logic [CW-1:0]   w_count_nxt;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_ovr_evt;
  logic            w_ovr_nxt;
  logic            w_tmo_nxt;
  logic            w_tmr_clr;
  logic            w_tmr_done;
  logic            w_int_nxt;
  logic [4:0]      w_thr;
  logic [4:0]      w_cnt_ext;
  rx_entry_t       w_head;

  // Occupancy flags and the push/pop/overrun decisions for this cycle.
  // A pop on a full FIFO frees the slot first, so a coincident push is taken.
  always_comb begin
    w_empty   = (r_count == {CW{1'b0}});
    w_full    = (r_count == DEPTH_C);
    w_pop     = rd_data & ~w_empty;
    w_push    = rx_valid & (~w_full | w_pop);
    w_ovr_evt = rx_valid & w_full & ~rd_data;
  end

  // Next occupancy count
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Sticky overrun: a new overrun beats a coincident status read
  always_comb begin
    w_ovr_nxt = r_ovr;
    if (w_ovr_evt) begin
      w_ovr_nxt = 1'b1;
    end else if (rd_status) begin
      w_ovr_nxt = 1'b0;
    end else begin
      w_ovr_nxt = r_ovr;
    end
  end

  // Timeout flag: cleared by a pop, set when the idle timer reaches its limit
  always_comb begin
    w_tmo_nxt = r_tmo;
    if (w_pop) begin
      w_tmo_nxt = 1'b0;
    end else if (w_tmr_done) begin
      w_tmo_nxt = 1'b1;
    end else begin
      w_tmo_nxt = r_tmo;
    end
  end

  // Interrupt level from current state; a threshold of 0 behaves as 1
  always_comb begin
    w_cnt_ext = 5'(r_count);
    if (thresh == 4'd0) begin
      w_thr = 5'd1;
    end else begin
      w_thr = {1'b0, thresh};
    end
    w_int_nxt = (w_cnt_ext >= w_thr) | r_ovr | r_tmo;
  end

  // Head entry and outputs; stale storage is masked while empty
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (w_empty) begin
      data_out   = 8'h00;
      status_out = pack_status(r_ovr, 2'b00, r_tmo, 4'(r_count));
    end else begin
      data_out   = w_head.data;
      status_out = pack_status(r_ovr, w_head.err, r_tmo, 4'(r_count));
    end
    int_req = r_int;
    empty   = w_empty;
    full    = w_full;
  end

  assign w_tmr_clr = w_push | w_pop | w_empty;

  uart_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_tmr_clr),
    .o_done (w_tmr_done)
  );

  // Storage write; contents are not reset since they are never visible when empty
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= '{err: rx_err, data: rx_data};
    end
  end

  // Pointers, count and flags with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovr    <= 1'b0;
      r_tmo    <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ovr   <= w_ovr_nxt;
      r_tmo   <= w_tmo_nxt;
      r_int   <= w_int_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model and a pop scoreboard.
module tb_uart_rx_fifo;

  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rd_data;
  logic       rd_status;
  logic [3:0] thresh;
  logic [7:0] data_out;
  logic [7:0] status_out;
  logic       int_req;
  logic       empty;
  logic       full;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .rd_data    (rd_data),
    .rd_status  (rd_status),
    .thresh     (thresh),
    .data_out   (data_out),
    .status_out (status_out),
    .int_req    (int_req),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected pop order (scoreboard) and model state
  logic [9:0] sb_q[$];
  logic [9:0] mq[$];
  bit         m_ovr;
  bit         m_tmo;
  bit         m_int;
  int         m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance by one clock edge given the inputs in force
  task automatic model_edge(input bit rv, input logic [7:0] d, input logic [1:0] e,
                            input bit rdd, input bit rds, input bit rn, input logic [3:0] th);
    int n;
    int t;
    bit int_n;
    bit pop;
    bit ovf;
    bit psh;
    if (!rn) begin
      mq.delete();
      sb_q.delete();
      m_ovr  = 1'b0;
      m_tmo  = 1'b0;
      m_int  = 1'b0;
      m_idle = 0;
    end else begin
      n     = mq.size();
      t     = (th == 4'd0) ? 1 : int'(th);
      int_n = (n >= t) || m_ovr || m_tmo;
      pop   = rdd && (n > 0);
      ovf   = rv && (n == DEPTH) && !rdd;
      psh   = rv && !ovf;
      if (pop) void'(mq.pop_front());
      if (psh) begin
        mq.push_back({e, d});
        sb_q.push_back({e, d});
      end
      if (ovf) m_ovr = 1'b1;
      else if (rds) m_ovr = 1'b0;
      if (pop || psh || n == 0) m_idle = 0;
      else if (m_idle < int'(TMO)) m_idle++;
      if (pop) m_tmo = 1'b0;
      else if (m_idle == int'(TMO)) m_tmo = 1'b1;
      m_int = int_n;
    end
  endtask

  // Compare every visible output against the model state
  task automatic check_outputs();
    logic [9:0] h;
    logic [3:0] c;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    c = 4'(mq.size());
    chk("data_out", data_out, h[7:0]);
    chk("status_out", status_out, {m_ovr, h[9:8], m_tmo, c});
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("int_req", int_req, m_int);
  endtask

  // One clock: drive inputs, predict, wait for the edge, check
  task automatic cycle(input bit rv, input logic [7:0] d, input logic [1:0] e,
                       input bit rdd, input bit rds, input bit rn, input logic [3:0] th);
    rx_valid  = rv;
    rx_data   = d;
    rx_err    = e;
    rd_data   = rdd;
    rd_status = rds;
    rst       = rn;
    thresh    = th;
    model_edge(rv, d, e, rdd, rds, rn, th);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic [3:0] th);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, th);
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] e, input logic [3:0] th);
    cycle(1'b1, d, e, 1'b0, 1'b0, 1'b1, th);
  endtask

  task automatic pop(input logic [3:0] th);
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, th);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1);
  endtask

  // Pop monitor: whenever the DUT pops, the head must match the scoreboard
  always @(negedge clk) begin
    logic [9:0] ex;
    if (rst && rd_data && !empty) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected no entry", data_out);
      end else begin
        ex = sb_q.pop_front();
        chk("pop.data", data_out, ex[7:0]);
        chk("pop.err", status_out[6:5], ex[9:8]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  mode;
    bit  rv;
    bit  rdd;
    bit  rds;
    bit  rn;
    logic [3:0] th;

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 2'b00;
    rd_data = 1'b0; rd_status = 1'b0; thresh = 4'd1;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    chk("rst.empty", empty, 1'b1);
    chk("rst.status", status_out, 8'h00);
    chk("rst.data", data_out, 8'h00);

    // Single push into empty FIFO, threshold 1
    push(8'hA5, 2'b00, 4'd1);
    chk("r036.data", data_out, 8'hA5);
    chk("r036.status", status_out, 8'h01);
    chk("r036.empty", empty, 1'b0);
    idle(4'd1);
    chk("r036.int", int_req, 1'b1);
    pop(4'd1);

    // Nine pushes: the ninth overflows
    do_reset();
    for (int i = 1; i <= 9; i++) push(8'(i), 2'b00, 4'd8);
    chk("r037.status", status_out, 8'h88);
    chk("r037.full", full, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk("r037.head", data_out, 8'(i));
      pop(4'd8);
    end
    chk("r037.empty", empty, 1'b1);

    // Status read coinciding with an overflow keeps OVR set
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 2'(i), 4'd8);
    rx_valid = 1'b1; rx_data = 8'h77; rd_status = 1'b1;
    #1;
    chk("r040.read_ovr", status_out[7], 1'b1);
    cycle(1'b1, 8'h77, 2'b00, 1'b0, 1'b1, 1'b1, 4'd8);
    chk("r040.ovr_kept", status_out[7], 1'b1);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 4'd8);
    chk("r040.ovr_clr", status_out[7], 1'b0);

    // Full FIFO with simultaneous push and pop
    cycle(1'b1, 8'h55, 2'b01, 1'b1, 1'b0, 1'b1, 4'd8);
    chk("r038.count", status_out[3:0], 4'd8);
    chk("r038.ovr", status_out[7], 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("r038.last", data_out, 8'h55);
      pop(4'd8);
    end

    // Idle timeout with one byte left
    push(8'h3C, 2'b10, 4'd8);
    for (int i = 0; i < 15; i++) idle(4'd8);
    chk("r039.tmo_early", status_out[4], 1'b0);
    idle(4'd8);
    chk("r039.tmo_set", status_out[4], 1'b1);
    idle(4'd8);
    chk("r039.int", int_req, 1'b1);
    pop(4'd8);
    chk("r039.tmo_clr", status_out[4], 1'b0);
    chk("r039.empty", empty, 1'b1);
    idle(4'd8);
    chk("r039.int_clr", int_req, 1'b0);

    // Reset mid-operation; strobes during reset are ignored
    push(8'hC1, 2'b00, 4'd1);
    push(8'hC2, 2'b01, 4'd1);
    push(8'hC3, 2'b10, 4'd1);
    cycle(1'b1, 8'hEE, 2'b11, 1'b1, 1'b1, 1'b0, 4'd1);
    chk("r041.empty", empty, 1'b1);
    chk("r041.status", status_out, 8'h00);
    chk("r041.int", int_req, 1'b0);
    chk("r041.data", data_out, 8'h00);

    // Randomized traffic in quiet / fill-heavy / drain-heavy blocks
    mode = 0;
    th   = 4'd4;
    for (int i = 0; i < 1500; i++) begin
      if (i % 48 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 49) == 0) th = 4'($urandom_range(0, 8));
      rn = ($urandom_range(0, 299) != 0);
      case (mode)
        0: begin
          rv  = ($urandom_range(0, 39) == 0);
          rdd = ($urandom_range(0, 59) == 0);
        end
        1: begin
          rv  = ($urandom_range(0, 9) < 7);
          rdd = ($urandom_range(0, 9) < 3);
        end
        default: begin
          rv  = ($urandom_range(0, 9) < 3);
          rdd = ($urandom_range(0, 9) < 6);
        end
      endcase
      rds = ($urandom_range(0, 15) == 0);
      cycle(rv, 8'($urandom), 2'($urandom), rdd, rds, rn, th);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
